// File: rtl/mem_buf_pkg.sv
//------------------------------------------------------------------------------
// mem_buf_pkg : shared types for the posted-write buffer | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_buf_pkg;

   localparam int WB_WIDTH = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      DONE     = 2'd2,
      WAIT_REL = 2'd3
   } wb_state_t;

   typedef struct packed {
      logic                valid;
      logic [WB_WIDTH-1:0] addr;
      logic [WB_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_lookup.sv
//------------------------------------------------------------------------------
// wb_lookup : youngest-match address search over live buffer entries | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_lookup #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]       i_valid,
   input  logic [DEPTH*WIDTH-1:0] i_addr,
   input  logic [DEPTH*WIDTH-1:0] i_data,
   input  logic [PW-1:0]          i_rd_ptr,
   input  logic [PW:0]            i_count,
   input  logic [WIDTH-1:0]       i_mar,
   output logic                   o_hit,
   output logic [WIDTH-1:0]       o_data
);

   logic [PW-1:0] w_idx;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = i_rd_ptr + PW'(i);
         if (((PW+1)'(i) < i_count) && i_valid[w_idx] &&
             (i_addr[int'(w_idx)*WIDTH +: WIDTH] == i_mar)) begin
            o_hit  = 1'b1;
            o_data = i_data[int'(w_idx)*WIDTH +: WIDTH];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_write_buffer.sv
//------------------------------------------------------------------------------
// mem_write_buffer : posted-write FIFO with read forwarding and flush | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_buffer
   import mem_buf_pkg::*;
#(
   parameter int WIDTH = WB_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cpu_memread,
   input  logic             i_cpu_memwrite,
   input  logic [WIDTH-1:0] i_cpu_mar,
   input  logic [WIDTH-1:0] i_cpu_writedata,
   output logic [WIDTH-1:0] o_cpu_memdata,
   output logic             o_stall,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic [WIDTH-1:0] o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wdata,
   input  logic [WIDTH-1:0] i_mem_rdata,
   input  logic             i_flush_req,
   output logic             o_flush_done,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   wb_state_t     r_state;
   logic          r_flush_done;

   logic [DEPTH-1:0]       w_valid;
   logic [DEPTH*WIDTH-1:0] w_addr;
   logic [DEPTH*WIDTH-1:0] w_data;
   logic                   w_lk_hit;
   logic [WIDTH-1:0]       w_lk_data;
   logic                   w_hit;
   logic                   w_rd_miss;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_drain;
   logic                   w_stall;
   logic                   w_push;
   logic [PW:0]            w_count_next;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_valid[g]                = r_mem[g].valid;
      assign w_addr[g*WIDTH +: WIDTH]  = r_mem[g].addr;
      assign w_data[g*WIDTH +: WIDTH]  = r_mem[g].data;
   end

   wb_lookup #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lookup (
      .i_valid  (w_valid),
      .i_addr   (w_addr),
      .i_data   (w_data),
      .i_rd_ptr (r_rd_ptr),
      .i_count  (r_count),
      .i_mar    (i_cpu_mar),
      .o_hit    (w_lk_hit),
      .o_data   (w_lk_data)
   );

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (PW+1)'(DEPTH));
   assign w_hit     = i_cpu_memread & w_lk_hit;
   assign w_rd_miss = i_cpu_memread & ~w_lk_hit;
   // A read miss owns the memory port, so draining waits a cycle.
   assign w_drain   = ~w_empty & ~w_rd_miss;
   assign w_stall   = i_cpu_memwrite & ((w_full & ~w_drain) | (r_state != RUN));
   assign w_push    = i_cpu_memwrite & ~w_stall;
   assign w_count_next = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_drain};

   assign o_cpu_memdata = w_hit ? w_lk_data : i_mem_rdata;
   assign o_mem_read    = w_rd_miss;
   assign o_mem_write   = w_drain;
   assign o_mem_addr    = w_rd_miss ? i_cpu_mar : r_mem[r_rd_ptr].addr;
   assign o_mem_wdata   = r_mem[r_rd_ptr].data;
   assign o_stall       = w_stall;
   assign o_empty       = w_empty;
   assign o_flush_done  = r_flush_done;

   // When full, push and pop hit the same slot; the later push assignment wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_drain) begin
            r_mem[r_rd_ptr].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + PW'(1);
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= '{valid: 1'b1, addr: i_cpu_mar, data: i_cpu_writedata};
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            RUN:      if (i_flush_req) r_state <= FLUSH;
            FLUSH:    if (w_count_next == '0) begin
                         r_state      <= DONE;
                         r_flush_done <= 1'b1;
                      end
            DONE:     r_state <= i_flush_req ? WAIT_REL : RUN;
            WAIT_REL: if (!i_flush_req) r_state <= RUN;
            default:  r_state <= RUN;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
//------------------------------------------------------------------------------
// tb_mem_write_buffer : directed self-checking bench for mem_write_buffer | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_memread, cpu_memwrite, flush_req;
   logic [7:0] cpu_mar, cpu_writedata, mem_rdata;
   logic [7:0] cpu_memdata, mem_addr, mem_wdata;
   logic       stall, mem_read, mem_write, flush_done, empty;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] img [256];
   logic [7:0] drain_log [$];

   always #5 clk = ~clk;

   mem_write_buffer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_cpu_memread   (cpu_memread),
      .i_cpu_memwrite  (cpu_memwrite),
      .i_cpu_mar       (cpu_mar),
      .i_cpu_writedata (cpu_writedata),
      .o_cpu_memdata   (cpu_memdata),
      .o_stall         (stall),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .o_mem_addr      (mem_addr),
      .o_mem_wdata     (mem_wdata),
      .i_mem_rdata     (mem_rdata),
      .i_flush_req     (flush_req),
      .o_flush_done    (flush_done),
      .o_empty         (empty)
   );

   always @(posedge clk) begin
      if (rst_n && mem_write) begin
         img[mem_addr] = mem_wdata;
         drain_log.push_back(mem_addr);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         n_assert++;
         assert (!(mem_read && mem_write)) else begin
            n_fail++;
            $error("FAIL rw_excl observed=%0b%0b expected=not both", mem_read, mem_write);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [7:0] mar,
                        input logic [7:0] wd, input logic fl);
      cpu_memread   = rd;
      cpu_memwrite  = wr;
      cpu_mar       = mar;
      cpu_writedata = wd;
      flush_req     = fl;
      #1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_rdata = 8'h00;
      drive(0, 0, 8'h00, 8'h00, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset in the middle of activity discards buffered writes
      drive(1, 1, 8'h01, 8'h11, 0); nxt();
      drive(1, 1, 8'h02, 8'h12, 0);
      chk("t1_pre_empty", 32'(empty), 32'd0);
      nxt();
      rst_n = 1'b0;
      drive(0, 1, 8'h03, 8'h13, 0);
      chk("t1_async_empty", 32'(empty), 32'd1);
      repeat (3) nxt();
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_stall", 32'(stall), 32'd0);
      chk("t1_mem_write", 32'(mem_write), 32'd0);
      chk("t1_flush_done", 32'(flush_done), 32'd0);
      drive(0, 0, 8'h00, 8'h00, 0);
      rst_n = 1'b1;
      nxt();

      // Single write drains on the next idle cycle
      drive(0, 1, 8'h4C, 8'h07, 0);
      chk("t2_stall", 32'(stall), 32'd0);
      chk("t2_no_write_yet", 32'(mem_write), 32'd0);
      nxt();
      drive(0, 0, 8'h00, 8'h00, 0);
      chk("t2_mem_write", 32'(mem_write), 32'd1);
      chk("t2_addr", 32'(mem_addr), 32'h4C);
      chk("t2_wdata", 32'(mem_wdata), 32'h07);
      nxt();
      chk("t2_empty", 32'(empty), 32'd1);
      chk("t2_idle_write", 32'(mem_write), 32'd0);

      // Fill under continuous read misses, fifth write stalls
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 8'(32'h20 + k), 8'(32'h30 + k), 0);
         chk("t3_fill_stall", 32'(stall), 32'd0);
         chk("t3_fill_mem_read", 32'(mem_read), 32'd1);
         nxt();
      end
      drive(1, 1, 8'h24, 8'h34, 0);
      chk("t3_full_stall", 32'(stall), 32'd1);
      chk("t3_full_mem_read", 32'(mem_read), 32'd1);
      nxt();
      chk("t3_full_stall_hold", 32'(stall), 32'd1);
      nxt();
      drive(0, 1, 8'h24, 8'h34, 0);
      chk("t3_release_stall", 32'(stall), 32'd0);
      chk("t3_first_drain", 32'(mem_write), 32'd1);
      chk("t3_first_addr", 32'(mem_addr), 32'h20);
      chk("t3_first_wdata", 32'(mem_wdata), 32'h30);
      nxt();
      drive(0, 0, 8'h00, 8'h00, 0);
      for (int k = 1; k < 5; k++) begin
         chk("t3_drain_write", 32'(mem_write), 32'd1);
         chk("t3_drain_addr", 32'(mem_addr), 32'h20 + 32'(k));
         chk("t3_drain_wdata", 32'(mem_wdata), 32'h30 + 32'(k));
         nxt();
      end
      chk("t3_empty", 32'(empty), 32'd1);

      // Forwarding with duplicate addresses, youngest wins
      drive(0, 1, 8'h12, 8'hCC, 0); nxt();
      drive(1, 1, 8'h10, 8'hAA, 0);
      chk("t4_miss_read", 32'(mem_read), 32'd1);
      chk("t4_miss_blocks_drain", 32'(mem_write), 32'd0);
      nxt();
      drive(1, 1, 8'h10, 8'hBB, 0);
      chk("t4_prewrite_data", 32'(cpu_memdata), 32'hAA);
      chk("t4_hit_no_read", 32'(mem_read), 32'd0);
      chk("t4_hit_drain", 32'(mem_write), 32'd1);
      chk("t4_hit_drain_addr", 32'(mem_addr), 32'h12);
      chk("t4_hit_drain_wdata", 32'(mem_wdata), 32'hCC);
      nxt();
      drive(1, 0, 8'h10, 8'h00, 0);
      chk("t4_youngest_data", 32'(cpu_memdata), 32'hBB);
      chk("t4_youngest_no_read", 32'(mem_read), 32'd0);
      chk("t4_dup_drain_addr", 32'(mem_addr), 32'h10);
      chk("t4_dup_drain_wdata", 32'(mem_wdata), 32'hAA);
      nxt();
      mem_rdata = 8'h5A;
      drive(1, 0, 8'h11, 8'h00, 0);
      chk("t4_miss11_read", 32'(mem_read), 32'd1);
      chk("t4_miss11_addr", 32'(mem_addr), 32'h11);
      chk("t4_miss11_data", 32'(cpu_memdata), 32'h5A);
      chk("t4_miss11_no_write", 32'(mem_write), 32'd0);
      nxt();
      drive(0, 0, 8'h00, 8'h00, 0);
      chk("t4_last_drain", 32'(mem_write), 32'd1);
      chk("t4_last_wdata", 32'(mem_wdata), 32'hBB);
      nxt();
      chk("t4_empty", 32'(empty), 32'd1);

      // Flush with three entries buffered
      drive(1, 1, 8'h40, 8'h01, 0); nxt();
      drive(1, 1, 8'h41, 8'h02, 0); nxt();
      drive(1, 1, 8'h42, 8'h03, 0); nxt();
      drive(0, 0, 8'h00, 8'h00, 1);
      chk("t5_f0_addr", 32'(mem_addr), 32'h40);
      chk("t5_f0_wdata", 32'(mem_wdata), 32'h01);
      chk("t5_f0_done", 32'(flush_done), 32'd0);
      nxt();
      drive(0, 1, 8'h50, 8'h99, 1);
      chk("t5_f1_stall", 32'(stall), 32'd1);
      chk("t5_f1_addr", 32'(mem_addr), 32'h41);
      chk("t5_f1_wdata", 32'(mem_wdata), 32'h02);
      nxt();
      chk("t5_f2_stall", 32'(stall), 32'd1);
      chk("t5_f2_addr", 32'(mem_addr), 32'h42);
      chk("t5_f2_wdata", 32'(mem_wdata), 32'h03);
      chk("t5_f2_done", 32'(flush_done), 32'd0);
      nxt();
      chk("t5_f3_done", 32'(flush_done), 32'd1);
      chk("t5_f3_stall", 32'(stall), 32'd1);
      chk("t5_f3_empty", 32'(empty), 32'd1);
      chk("t5_f3_no_write", 32'(mem_write), 32'd0);
      nxt();
      chk("t5_f4_done", 32'(flush_done), 32'd0);
      chk("t5_f4_stall", 32'(stall), 32'd1);
      drive(0, 1, 8'h50, 8'h99, 0);
      nxt();
      chk("t5_f5_stall", 32'(stall), 32'd0);
      chk("t5_f5_done", 32'(flush_done), 32'd0);
      nxt();
      drive(0, 0, 8'h00, 8'h00, 0);
      chk("t5_post_addr", 32'(mem_addr), 32'h50);
      chk("t5_post_wdata", 32'(mem_wdata), 32'h99);
      nxt();
      chk("t5_post_empty", 32'(empty), 32'd1);

      // Flush of an empty buffer pulses two cycles after the request
      drive(0, 0, 8'h00, 8'h00, 1);
      chk("t5e_c0_done", 32'(flush_done), 32'd0);
      nxt();
      chk("t5e_c1_done", 32'(flush_done), 32'd0);
      nxt();
      chk("t5e_c2_done", 32'(flush_done), 32'd1);
      drive(0, 0, 8'h00, 8'h00, 0);
      nxt();
      chk("t5e_c3_done", 32'(flush_done), 32'd0);

      // Ten writes with mixed drains, pointers wrap
      drain_log.delete();
      for (int i = 0; i < 10; i++) begin
         drive(((i % 3) == 0), 1, 8'(32'h60 + i), 8'(32'h80 + i), 0);
         chk("t6_stall", 32'(stall), 32'd0);
         nxt();
      end
      drive(0, 0, 8'h00, 8'h00, 0);
      for (int t = 0; t < 20 && !empty; t++) nxt();
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_log_size", 32'(drain_log.size()), 32'd10);
      for (int k = 0; k < 10; k++) begin
         chk("t6_order", (k < drain_log.size()) ? 32'(drain_log[k]) : 32'hFFFF, 32'h60 + 32'(k));
         chk("t6_image", 32'(img[8'(32'h60 + k)]), 32'h80 + 32'(k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
